period_meter: RTL and testbench
===============================

// Module: period_meter
// PURPOSE
//  Measures the period of an incoming reference clock (clk_in), sampled on the system clock.
//  Drives period_length_1000 (period in ps, i.e. ns*1000) and period_stable.
//  Feeds the ref_period_1000 / period_stable inputs of freq_gen; it is the producer side of that interface.
//  Replaces the ideal testbench-driven period with a synthesizable measurement.
// PARAMETERS
//  SAMPLE_PERIOD_1000  1000     period of clk in ps; scales cycle count to ps
//  CNT_W               24       width of the cycle counter
//  STABLE_COUNT        4        consecutive matching measurements required for period_stable
//  TOLERANCE           0        max |cur-prev| in clk cycles still counted as a match
//  TIMEOUT_CYCLES      2**20-1  clk cycles without a clk_in edge before measurement is dropped
// PORTS
//  clk                    in   1   sampling clock; all logic on its rising edge
//  RST_n                  in   1   asynchronous active-low reset
//  PWRDWN                 in   1   synchronous power-down; forces idle and clears outputs
//  clk_in                 in   1   asynchronous reference clock being measured
//  period_length_1000     out  32  measured period in ps (cycles * SAMPLE_PERIOD_1000)
//  period_stable          out  1   1 = last STABLE_COUNT measurements matched within TOLERANCE
//  meas_done              out  1   one-cycle strobe; a new measurement was written this cycle
// BEHAVIOUR
//  Reset (RST_n=0, async): state=S_IDLE, count=0, match_cnt=0, prev=0; all outputs 0.
//  clk_in goes through a 2-FF synchronizer and a rising-edge detector; edge = 1-cycle pulse.
//  Latency: clk_in rise -> edge pulse 3 clk later; outputs update on the clk after edge.
//  FSM:
//   S_IDLE : count=0; on edge -> S_COUNT, count<=1; no measurement produced.
//   S_FIRST: (merged into S_COUNT via first_flag) first captured period has no predecessor.
//   S_COUNT: count<=count+1 each cycle.
//    On edge: cur=count; count<=1; meas_done<=1; period_length_1000<=cur*SAMPLE_PERIOD_1000.
//     Product saturates at 32'hFFFF_FFFF.
//     If first_flag: prev<=cur, match_cnt<=0, first_flag<=0.
//     Else if |cur-prev|<=TOLERANCE: match_cnt<=min(match_cnt+1,STABLE_COUNT).
//     Else: match_cnt<=0 and period_stable<=0 in the same cycle.
//     prev<=cur always.
//    count==TIMEOUT_CYCLES with no edge -> S_IDLE: period_stable=0, period_length_1000=0, first_flag=1.
//  period_stable is registered: 1 iff match_cnt==STABLE_COUNT.
//   From S_IDLE it first asserts on the (STABLE_COUNT+2)-th detected edge.
//  count never wraps: it saturates at TIMEOUT_CYCLES, and the timeout has priority.
//   An edge in the same cycle as the timeout is ignored.
//  PWRDWN=1: same values as reset, applied synchronously; held while PWRDWN=1.
//   Measurement restarts from S_IDLE once PWRDWN is deasserted.
//  Glitch/duty: only rising edges count; duty cycle is irrelevant.
//   clk_in pulses shorter than one clk period may be missed; this is accepted.
// CONFIGURATION
//  PERIOD_METER_AVG_EN defined:
//   period_length_1000 = (sum of last 4 cur values * SAMPLE_PERIOD_1000) >> 2.
//   A 4-entry history is cleared on reset, PWRDWN and timeout.
//   Until 4 entries exist, the average is taken over the entries present (1, 2 or 4 divisors; 3 uses 2 newest).
//  PERIOD_METER_AVG_EN undefined: raw last measurement; no history registers.
//  period_stable logic is identical in both builds.
// STRUCTURE
//  period_meter_defs.vh (shared include):
//   state encodings S_IDLE=1'b0, S_COUNT=1'b1; SAT_MAX=32'hFFFF_FFFF.
//  Sub-module edge_sync: 2-FF synchronizer plus rising-edge pulse (clk, RST_n, d, rise).
//   Reused by later clock-domain blocks.
// TESTING (clk 1 ns, defaults, include high_counter cross-check where useful)
//  1 clk_in 20 ns:
//     first meas_done on 2nd edge with period_length_1000=20000;
//     period_stable=1 after the 6th detected edge, then stays 1.
//  2 Switch clk_in 20 ns -> 10 ns:
//     period_stable=0 on the first 10 ns measurement;
//     re-asserts after 4 more matching edges; length=10000.
//  3 clk_in 5.6 ns (edges every 5 or 6 clk):
//     TOLERANCE=0 -> period_stable stays 0;
//     TOLERANCE=1 -> period_stable=1; length in {5000,6000}.
//  4 Stop clk_in after stable:
//     TIMEOUT_CYCLES (set to 100) clk later, period_stable=0 and length=0;
//     restart clk_in -> re-locks.
//  5 Drop RST_n mid-count:
//     all outputs 0 immediately (async, no clk);
//     PWRDWN=1 clears them on the next clk; both restart from S_IDLE.
//  6 AVG_EN build, alternating 19/21 ns periods:
//     period_length_1000=20000 after 4 measurements.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared state encoding, saturation limit and helpers for the period meter.
package period_meter_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

  // Clamp a wide product into the 32-bit period output.
  function automatic logic [31:0] sat32(input logic [63:0] v);
    return (|v[63:32]) ? SAT_MAX : v[31:0];
  endfunction

endpackage

// File: rtl/period_meter_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse; rise is high for one clk
// cycle, three clk edges after the asynchronous input goes high.
module period_meter_edge_sync (
  input  logic clk,
  input  logic RST_n,
  input  logic d,
  output logic rise
);

  logic [2:0] sync_q;
  logic       rise_q;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/period_meter.sv
// Measures the period of clk_in in clk cycles, scaled to ps, and flags when it is stable.
// Define PERIOD_METER_AVG_EN to report a running average of the last four measurements.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD_1000 = 1000,
  parameter int unsigned CNT_W              = 24,
  parameter int unsigned STABLE_COUNT       = 4,
  parameter int unsigned TOLERANCE          = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 2**20 - 1
) (
  input  logic        clk,
  input  logic        RST_n,
  input  logic        PWRDWN,
  input  logic        clk_in,
  output logic [31:0] period_length_1000,
  output logic        period_stable,
  output logic        meas_done
);

  localparam int unsigned       MatchW     = $clog2(STABLE_COUNT + 2);
  localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  TolVal     = CNT_W'(TOLERANCE);
  localparam logic [CNT_W-1:0]  CntOne     = CNT_W'(1);
  localparam logic [MatchW-1:0] MatchMax   = MatchW'(STABLE_COUNT);
  localparam logic [MatchW-1:0] MatchOne   = MatchW'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]   diff;
  logic [MatchW-1:0]  match_q, match_d;
  logic               first_q, first_d;
  logic [31:0]        len_q, len_d;
  logic               stable_q, stable_d;
  logic               done_q, done_d;
  logic               rise, timeout_hit, meas_hit, within_tol;
  logic [63:0]        scaled;

  period_meter_edge_sync u_edge_sync (
    .clk   (clk),
    .RST_n (RST_n),
    .d     (clk_in),
    .rise  (rise)
  );

  // Timeout wins over a coincident edge.
  assign timeout_hit = (state_q == S_COUNT) && (count_q == TimeoutVal);
  assign meas_hit    = (state_q == S_COUNT) && !timeout_hit && rise;
  assign diff        = (count_q >= prev_q) ? (count_q - prev_q) : (prev_q - count_q);
  assign within_tol  = (diff <= TolVal);

`ifdef PERIOD_METER_AVG_EN
  localparam int unsigned SumW = CNT_W + 2;

  // Three stored entries plus the current count form the four-entry window.
  logic [2:0][CNT_W-1:0] hist_q, hist_d;
  logic [3:0][CNT_W-1:0] hist_new;
  logic [2:0]            hist_n_q, hist_n_d, hist_n_new;
  logic [SumW-1:0]       hist_sum;
  logic [1:0]            hist_shift;

  assign hist_new   = {hist_q, count_q};
  assign hist_n_new = (hist_n_q == 3'd4) ? 3'd4 : hist_n_q + 3'd1;

  always_comb begin
    hist_sum   = '0;
    hist_shift = '0;
    case (hist_n_new)
      3'd1: hist_sum = SumW'(hist_new[0]);
      3'd2, 3'd3: begin
        hist_sum   = SumW'(hist_new[0]) + SumW'(hist_new[1]);
        hist_shift = 2'd1;
      end
      default: begin
        hist_sum   = SumW'(hist_new[0]) + SumW'(hist_new[1]) +
                     SumW'(hist_new[2]) + SumW'(hist_new[3]);
        hist_shift = 2'd2;
      end
    endcase
  end

  assign scaled = (64'(hist_sum) * 64'(SAMPLE_PERIOD_1000)) >> hist_shift;

  always_comb begin
    hist_d   = hist_q;
    hist_n_d = hist_n_q;
    if (PWRDWN || timeout_hit) begin
      hist_d   = '0;
      hist_n_d = '0;
    end else if (meas_hit) begin
      hist_d   = hist_new[2:0];
      hist_n_d = hist_n_new;
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      hist_q   <= '0;
      hist_n_q <= '0;
    end else begin
      hist_q   <= hist_d;
      hist_n_q <= hist_n_d;
    end
  end
`else
  assign scaled = 64'(count_q) * 64'(SAMPLE_PERIOD_1000);
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    prev_d   = prev_q;
    match_d  = match_q;
    first_d  = first_q;
    len_d    = len_q;
    stable_d = stable_q;
    done_d   = 1'b0;
    if (PWRDWN) begin
      state_d  = S_IDLE;
      count_d  = '0;
      prev_d   = '0;
      match_d  = '0;
      first_d  = 1'b1;
      len_d    = '0;
      stable_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          count_d = '0;
          if (rise) begin
            state_d = S_COUNT;
            count_d = CntOne;
          end
        end
        S_COUNT: begin
          if (timeout_hit) begin
            state_d  = S_IDLE;
            count_d  = '0;
            match_d  = '0;
            first_d  = 1'b1;
            len_d    = '0;
            stable_d = 1'b0;
          end else if (meas_hit) begin
            count_d = CntOne;
            done_d  = 1'b1;
            len_d   = sat32(scaled);
            prev_d  = count_q;
            if (first_q) begin
              match_d = '0;
              first_d = 1'b0;
            end else if (within_tol) begin
              if (match_q != MatchMax) match_d = match_q + MatchOne;
            end else begin
              match_d = '0;
            end
            stable_d = (match_d == MatchMax);
          end else begin
            count_d = count_q + CntOne;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      prev_q   <= '0;
      match_q  <= '0;
      first_q  <= 1'b1;
      len_q    <= '0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      prev_q   <= prev_d;
      match_q  <= match_d;
      first_q  <= first_d;
      len_q    <= len_d;
      stable_q <= stable_d;
      done_q   <= done_d;
    end
  end

  assign period_length_1000 = len_q;
  assign period_stable      = stable_q;
  assign meas_done          = done_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: three instances (exact match, tolerance 1, saturating scale)
// share one clk_in; expected measurements are queued at each edge and popped on meas_done.
module tb_period_meter;

  localparam longint unsigned SpStd = 1000;
  localparam longint unsigned SpBig = 300_000_000;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pwrdwn = 1'b0;
  logic        clk_in = 1'b0;
  logic [31:0] len0, len1, len2;
  logic        stable0, stable1, stable2;
  logic        done0, done1, done2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] len_std;
    logic [31:0] len_big;
    logic        s0;
    logic        s1;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  exp_t mon_e;

  always #5 clk = ~clk;

  period_meter #(.TOLERANCE(0), .TIMEOUT_CYCLES(100)) dut0 (
    .clk(clk), .RST_n(rst_n), .PWRDWN(pwrdwn), .clk_in(clk_in),
    .period_length_1000(len0), .period_stable(stable0), .meas_done(done0)
  );

  period_meter #(.TOLERANCE(1), .TIMEOUT_CYCLES(100)) dut1 (
    .clk(clk), .RST_n(rst_n), .PWRDWN(pwrdwn), .clk_in(clk_in),
    .period_length_1000(len1), .period_stable(stable1), .meas_done(done1)
  );

  period_meter #(.SAMPLE_PERIOD_1000(300_000_000), .TOLERANCE(0), .TIMEOUT_CYCLES(100)) dut2 (
    .clk(clk), .RST_n(rst_n), .PWRDWN(pwrdwn), .clk_in(clk_in),
    .period_length_1000(len2), .period_stable(stable2), .meas_done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] sat32(input longint unsigned v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

`ifdef PERIOD_METER_AVG_EN
  int unsigned hist[$];
`endif

  task automatic hist_clear();
`ifdef PERIOD_METER_AVG_EN
    hist.delete();
`endif
  endtask

  // Expected output for a measurement of 'cur' clk cycles.
  task automatic push_expect(input int cur, input bit s0, input bit s1);
    longint unsigned sum;
    int sh;
    exp_t e;
`ifdef PERIOD_METER_AVG_EN
    hist.push_front(cur);
    if (hist.size() > 4) void'(hist.pop_back());
    case (hist.size())
      1: begin sum = hist[0]; sh = 0; end
      2, 3: begin sum = longint'(hist[0]) + hist[1]; sh = 1; end
      default: begin sum = longint'(hist[0]) + hist[1] + hist[2] + hist[3]; sh = 2; end
    endcase
`else
    sum = longint'(cur);
    sh  = 0;
`endif
    e.len_std = sat32((sum * SpStd) >> sh);
    e.len_big = sat32((sum * SpBig) >> sh);
    e.s0      = s0;
    e.s1      = s1;
    last_e    = e;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done0 || done1 || done2) begin
      check("meas_done dut0", 32'(done0), 32'd1);
      check("meas_done dut1", 32'(done1), 32'd1);
      check("meas_done dut2", 32'(done2), 32'd1);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: meas_done with no expected measurement, len0=%0d", len0);
      end else begin
        mon_e = sb.pop_front();
        check("len dut0", len0, mon_e.len_std);
        check("len dut1", len1, mon_e.len_std);
        check("len dut2 (scaled/sat)", len2, mon_e.len_big);
        check("stable dut0", 32'(stable0), 32'(mon_e.s0));
        check("stable dut1", 32'(stable1), 32'(mon_e.s1));
        check("stable dut2", 32'(stable2), 32'(mon_e.s0));
      end
    end
  end

  task automatic start_edge();
    clk_in = 1'b1;
    @(negedge clk);
    clk_in = 1'b0;
  endtask

  // Rise exactly 'cur' clk cycles after the previous rise.
  task automatic ev(input int cur, input bit s0, input bit s1);
    repeat (cur - 1) @(negedge clk);
    push_expect(cur, s0, s1);
    start_edge();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " len dut0"}, len0, 32'd0);
    check({tag, " len dut1"}, len1, 32'd0);
    check({tag, " len dut2"}, len2, 32'd0);
    check({tag, " stable dut0"}, 32'(stable0), 32'd0);
    check({tag, " stable dut1"}, 32'(stable1), 32'd0);
    check({tag, " stable dut2"}, 32'(stable2), 32'd0);
    check({tag, " meas_done dut0"}, 32'(done0), 32'd0);
  endtask

  initial begin
    #23;
    check_zero("in reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check_zero("idle after reset");

    // 20-cycle period: first result on edge 2, stable from edge 6.
    start_edge();
    repeat (4) ev(20, 1'b0, 1'b0);
    ev(20, 1'b1, 1'b1);
    ev(20, 1'b1, 1'b1);

    // Switch to 10 cycles: drop, then relock after four matches.
    ev(10, 1'b0, 1'b0);
    repeat (3) ev(10, 1'b0, 1'b0);
    ev(10, 1'b1, 1'b1);
    ev(10, 1'b1, 1'b1);

    // Alternating 5/6: only the tolerance-1 instance locks.
    ev(5, 1'b0, 1'b0);
    ev(6, 1'b0, 1'b0);
    ev(5, 1'b0, 1'b0);
    ev(6, 1'b0, 1'b0);
    ev(5, 1'b0, 1'b1);
    ev(6, 1'b0, 1'b1);

    // Stop clk_in: still held before the timeout, cleared after it.
    idle(60);
    check("pre-timeout len dut0", len0, last_e.len_std);
    check("pre-timeout len dut2", len2, last_e.len_big);
    check("pre-timeout stable dut1", 32'(stable1), 32'd1);
    check("pre-timeout stable dut0", 32'(stable0), 32'd0);
    idle(80);
    check_zero("after timeout");
    hist_clear();
    start_edge();
    repeat (4) ev(20, 1'b0, 1'b0);
    ev(20, 1'b1, 1'b1);

    // Asynchronous reset mid-count, checked before the next clk edge.
    idle(10);
    check("pre-reset stable dut0", 32'(stable0), 32'd1);
    #3 rst_n = 1'b0;
    #1 check_zero("async reset");
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    hist_clear();
    idle(2);
    start_edge();
    repeat (4) ev(20, 1'b0, 1'b0);
    ev(20, 1'b1, 1'b1);
    ev(20, 1'b1, 1'b1);

    // Power-down clears on the next clk and suppresses measurement while held.
    idle(8);
    pwrdwn = 1'b1;
    idle(1);
    check_zero("pwrdwn");
    start_edge();
    idle(5);
    start_edge();
    idle(5);
    start_edge();
    idle(10);
    check_zero("pwrdwn held");
    pwrdwn = 1'b0;
    hist_clear();
    idle(5);

    // Alternating 19/21 cycles from a fresh start.
    start_edge();
    ev(19, 1'b0, 1'b0);
    ev(21, 1'b0, 1'b0);
    ev(19, 1'b0, 1'b0);
    ev(21, 1'b0, 1'b0);
`ifdef PERIOD_METER_AVG_EN
    idle(8);
    check("avg len after 4 measurements", len0, 32'd20000);
    repeat (11) @(negedge clk);
`endif
    ev(19, 1'b0, 1'b0);
    idle(10);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
